// File: rtl/dino_sprite_renderer.sv
// Dino sprite renderer: maps scan coordinates to sprite-ROM addresses and emits a
// per-pixel colour/valid stream three cycles after the sampled coordinates. Also
// reports whether any opaque dino pixel overlapped an obstacle during the previous frame.
module dino_sprite_renderer #(
  parameter int unsigned SPR_W  = 44,
  parameter int unsigned SPR_H  = 47,
  parameter int unsigned ADDR_W = 14,
  parameter logic [11:0] TKEY   = 12'hFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        sel_i,
  input  logic [9:0]        dino_x_i,
  input  logic [9:0]        dino_y_i,
  input  logic              frame_start_i,
  input  logic              de_i,
  input  logic [9:0]        h_cnt_i,
  input  logic [9:0]        v_cnt_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [11:0]       rom_data_i,
  input  logic              obstacle_hit_i,
  output logic              pixel_valid_o,
  output logic [11:0]       pixel_rgb_o,
  output logic              collide_o
);

  localparam int unsigned FrameSz = SPR_W * SPR_H;

  // Per-frame latched state; armed_q keeps the output blank until the first frame_start.
  logic [3:0] sel_l_q;
  logic [9:0] x_l_q, y_l_q;
  logic       armed_q;

  // Pipeline state.
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, hit2_q;
  logic              pixel_valid_q, pixel_valid_d;
  logic [11:0]       pixel_rgb_q, pixel_rgb_d;

  // Collision accumulator.
  logic acc_q, acc_d;
  logic collide_q, collide_d;

  logic [2:0]        idx;
  logic [ADDR_W-1:0] base;
  logic [10:0]       col, row, x_end, y_end;
  logic              hit;
  logic              overlap;

  // Latch select code and position once per frame so the sprite never tears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_l_q <= 4'b0000;
      x_l_q   <= '0;
      y_l_q   <= '0;
      armed_q <= 1'b0;
    end else if (frame_start_i) begin
      sel_l_q <= sel_i;
      x_l_q   <= dino_x_i;
      y_l_q   <= dino_y_i;
      armed_q <= 1'b1;
    end
  end

  // Decode latched select code into a sprite frame index and its ROM base address.
  always_comb begin
    idx = 3'd0;
    case (sel_l_q)
      4'b0001: idx = 3'd1;
      4'b0010: idx = 3'd2;
      4'b1011: idx = 3'd3;
      4'b0011: idx = 3'd4;
      4'b0111: idx = 3'd5;
      default: idx = 3'd0;
    endcase
    base = ADDR_W'(idx) * ADDR_W'(FrameSz);
  end

  // Stage 1: window test and address generation; 11-bit sums avoid wrap past the screen edge.
  always_comb begin
    col   = {1'b0, h_cnt_i} - {1'b0, x_l_q};
    row   = {1'b0, v_cnt_i} - {1'b0, y_l_q};
    x_end = {1'b0, x_l_q} + 11'(SPR_W);
    y_end = {1'b0, y_l_q} + 11'(SPR_H);
    hit   = armed_q & de_i
          & (h_cnt_i >= x_l_q) & ({1'b0, h_cnt_i} < x_end)
          & (v_cnt_i >= y_l_q) & ({1'b0, v_cnt_i} < y_end);
    rom_addr_d = '0;
    if (hit) begin
      rom_addr_d = base + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end
  end

  // Stage 3: transparent-key test on the ROM data returned for the stage-1 address.
  always_comb begin
    pixel_valid_d = hit2_q & (rom_data_i != TKEY);
    pixel_rgb_d   = pixel_valid_d ? rom_data_i : 12'h000;
  end

  // Pixel pipeline registers; the ROM itself provides the stage-2 register for data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom_addr_q    <= '0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_rgb_q   <= 12'h000;
    end else begin
      rom_addr_q    <= rom_addr_d;
      hit1_q        <= hit;
      hit2_q        <= hit1_q;
      pixel_valid_q <= pixel_valid_d;
      pixel_rgb_q   <= pixel_rgb_d;
    end
  end

  // Overlap on the frame_start cycle is credited to the frame just ending.
  always_comb begin
    overlap   = pixel_valid_q & obstacle_hit_i;
    acc_d     = acc_q | overlap;
    collide_d = collide_q;
    if (frame_start_i) begin
      collide_d = acc_q | overlap;
      acc_d     = 1'b0;
    end
  end

  // Collision accumulator and per-frame result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign rom_addr_o    = rom_addr_q;
  assign pixel_valid_o = pixel_valid_q;
  assign pixel_rgb_o   = pixel_rgb_q;
  assign collide_o     = collide_q;

endmodule

// File: tb/tb_dino_sprite_renderer.sv
// Scoreboard bench for dino_sprite_renderer: stimulus pushes timestamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dino_sprite_renderer;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  logic [9:0]  dino_x, dino_y;
  logic        frame_start;
  logic        de;
  logic [9:0]  h_cnt, v_cnt;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic        obstacle_hit;
  logic        pixel_valid;
  logic [11:0] pixel_rgb;
  logic        collide;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [13:0] key_addr;

  typedef struct {
    int          due;
    logic [13:0] val;
    logic        v;
  } chk_t;

  chk_t addr_q[$];
  chk_t pix_q[$];
  chk_t col_q[$];

  dino_sprite_renderer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sel_i          (sel),
    .dino_x_i       (dino_x),
    .dino_y_i       (dino_y),
    .frame_start_i  (frame_start),
    .de_i           (de),
    .h_cnt_i        (h_cnt),
    .v_cnt_i        (v_cnt),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .obstacle_hit_i (obstacle_hit),
    .pixel_valid_o  (pixel_valid),
    .pixel_rgb_o    (pixel_rgb),
    .collide_o      (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sprite ROM model: one address marked transparent, everything else a simple pattern.
  function automatic logic [11:0] rom_fn(input logic [13:0] a);
    if (a == key_addr) return 12'hFFF;
    return a[11:0] ^ 12'h0A5;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic push_addr(input int due, input logic [13:0] exp);
    chk_t e;
    e.due = due; e.val = exp; e.v = 1'b0;
    addr_q.push_back(e);
  endtask

  task automatic push_pix(input int due, input logic v, input logic [11:0] rgb);
    chk_t e;
    int i;
    e.due = due; e.val = {2'b00, rgb}; e.v = v;
    i = 0;
    while (i < pix_q.size() && pix_q[i].due <= due) i++;
    pix_q.insert(i, e);
  endtask

  task automatic push_col(input int due, input logic exp);
    chk_t e;
    e.due = due; e.val = '0; e.v = exp;
    col_q.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    chk_t e;
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      e = addr_q.pop_front();
      n_tests++;
      if (e.due != cyc || rom_addr !== e.val) begin
        n_fail++;
        $display("FAIL rom_addr cyc=%0d due=%0d got=%0d exp=%0d", cyc, e.due, rom_addr, e.val);
      end
    end
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      n_tests++;
      if (e.due != cyc || pixel_valid !== e.v || pixel_rgb !== e.val[11:0]) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d due=%0d got=%b/%h exp=%b/%h",
                 cyc, e.due, pixel_valid, pixel_rgb, e.v, e.val[11:0]);
      end
    end
    while (col_q.size() > 0 && col_q[0].due <= cyc) begin
      e = col_q.pop_front();
      n_tests++;
      if (e.due != cyc || collide !== e.v) begin
        n_fail++;
        $display("FAIL collide cyc=%0d due=%0d got=%b exp=%b", cyc, e.due, collide, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame pulse during blanking; collide is checked right after it takes effect.
  task automatic frame(input logic [3:0] s, input logic [9:0] x, input logic [9:0] y,
                       input logic exp_col);
    sel = s; dino_x = x; dino_y = y; frame_start = 1'b1; de = 1'b0;
    tick();
    frame_start = 1'b0;
    push_col(cyc, exp_col);
  endtask

  // One scanned pixel: address due next cycle, pixel three cycles after the sample.
  task automatic scan(input logic [9:0] h, input logic [9:0] v, input logic [13:0] exp_addr,
                      input logic exp_hit);
    logic [11:0] d;
    d = rom_fn(exp_addr);
    h_cnt = h; v_cnt = v; de = 1'b1;
    push_addr(cyc + 1, exp_addr);
    if (exp_hit && d != 12'hFFF) push_pix(cyc + 3, 1'b1, d);
    else push_pix(cyc + 3, 1'b0, 12'h000);
    tick();
    de = 1'b0;
  endtask

  // Opaque dino pixel with an obstacle aligned to it.
  task automatic hit_obstacle();
    scan(10'd100, 10'd200, 14'd0, 1'b1);
    tick();
    tick();
    obstacle_hit = 1'b1;
    tick();
    obstacle_hit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = '0; dino_x = '0; dino_y = '0; frame_start = 1'b0; de = 1'b0;
    h_cnt = '0; v_cnt = '0; obstacle_hit = 1'b0; key_addr = 14'h3FFF;
    tick();
    tick();
    rst = 1'b0;
    push_addr(cyc, 14'd0);
    push_pix(cyc, 1'b0, 12'h000);
    push_col(cyc, 1'b0);

    // Blank before the first frame_start even though latched x/y are zero.
    scan(10'd0, 10'd0, 14'd0, 1'b0);

    frame(4'b0111, 10'd100, 10'd200, 1'b0);
    scan(10'd100, 10'd200, 14'd10340, 1'b1);
    scan(10'd143, 10'd246, 14'd12407, 1'b1);
    scan(10'd144, 10'd246, 14'd0, 1'b0);
    scan(10'd100, 10'd247, 14'd0, 1'b0);
    scan(10'd99, 10'd200, 14'd0, 1'b0);

    frame(4'b1111, 10'd100, 10'd200, 1'b0);
    scan(10'd100, 10'd200, 14'd0, 1'b1);
    frame(4'b0001, 10'd100, 10'd200, 1'b0);
    scan(10'd100, 10'd200, 14'd2068, 1'b1);
    scan(10'd101, 10'd201, 14'd2113, 1'b1);

    // Select change without frame_start must not take effect.
    frame(4'b0011, 10'd100, 10'd200, 1'b0);
    scan(10'd100, 10'd200, 14'd8272, 1'b1);
    sel = 4'b0010;
    scan(10'd100, 10'd200, 14'd8272, 1'b1);
    frame(4'b0010, 10'd100, 10'd200, 1'b0);
    scan(10'd100, 10'd200, 14'd4136, 1'b1);
    frame(4'b1011, 10'd100, 10'd200, 1'b0);
    scan(10'd100, 10'd200, 14'd6204, 1'b1);

    // Right-edge clipping without wrap, and transparent key.
    frame(4'b0000, 10'd620, 10'd10, 1'b0);
    scan(10'd639, 10'd10, 14'd19, 1'b1);
    scan(10'd0, 10'd10, 14'd0, 1'b0);
    key_addr = 14'd19;
    scan(10'd639, 10'd10, 14'd19, 1'b1);
    tick();
    tick();
    key_addr = 14'h3FFF;
    frame(4'b0000, 10'd0, 10'd470, 1'b0);
    scan(10'd0, 10'd479, 14'd396, 1'b1);

    // Mid-frame overlap: reported after the next frame_start, cleared after the following.
    frame(4'b0000, 10'd100, 10'd200, 1'b0);
    hit_obstacle();
    frame(4'b0000, 10'd100, 10'd200, 1'b1);
    frame(4'b0000, 10'd100, 10'd200, 1'b0);

    // Overlap on the frame_start cycle itself belongs to the ending frame.
    scan(10'd100, 10'd200, 14'd0, 1'b1);
    tick();
    tick();
    obstacle_hit = 1'b1;
    sel = 4'b0000; dino_x = 10'd100; dino_y = 10'd200; frame_start = 1'b1;
    tick();
    obstacle_hit = 1'b0;
    frame_start = 1'b0;
    push_col(cyc, 1'b1);
    frame(4'b0000, 10'd100, 10'd200, 1'b0);

    // Reset mid-frame with collide set and a pixel in flight.
    hit_obstacle();
    frame(4'b0111, 10'd100, 10'd200, 1'b1);
    scan(10'd100, 10'd200, 14'd10340, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_addr(cyc, 14'd0);
    push_pix(cyc, 1'b0, 12'h000);
    push_col(cyc, 1'b0);
    tick();
    scan(10'd100, 10'd200, 14'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (addr_q.size() == 0 && pix_q.size() == 0 && col_q.size() == 0) break;
      tick();
    end
    if (addr_q.size() != 0 || pix_q.size() != 0 || col_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", addr_q.size() + pix_q.size() + col_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
